lvds_photon_trigger: RTL

Parametrised photon-trigger stage fed by the deserialised LVDS PMT sample word. Each clock it receives NBINS time-ordered bins, optionally reduces them to leading edges across word boundaries, and maps a phase-selected window of bins onto NCH output channels. Each channel drives a retriggerable-free pulse with programmable firing width and dead time. Per-bin hit histograms can be read out through a registered mux.

---
 rtl/lvds_photon_trigger_if.sv | 54 +++++
 rtl/lvds_photon_trigger.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_photon_trigger_if.sv
// lvds_photon_trigger_if
// Groups the sample, configuration, histogram readout and trigger signals
// of the photon-trigger stage. The clock and reset stay as plain ports.
//   master : the side that supplies samples and configuration and observes
//            trig_out / hist_data
//   slave  : the trigger stage itself
// Ports carried:
//   lvds_rx[NBINS]    deserialised PMT sample word, bin 0 earliest
//   pmt_in            raw PMT level for passthrough
//   passthrough       route pmt_in straight to trig_out[0]
//   vetopmtlast       leading-edge reduction of the sample word
//   usefullwidth      let sub-bins 1..BPC-1 trigger their channel
//   phaseoffset[OW]   first bin of the channel window
//   firingticks[8]    output pulse width in cycles
//   deadticks[8]      dead time in cycles
//   resethist         clear all histogram counters
//   hist_sel[SW]      histogram index to read
//   hist_data[HISTW]  registered histogram value
//   trig_out[NCH]     channel trigger outputs
interface lvds_photon_trigger_if #(
  parameter int NBINS = 8,
  parameter int NCH   = 2,
  parameter int BPC   = 2,
  parameter int HISTW = 32
);
  localparam int NH = NCH * BPC;
  localparam int OW = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int SW = (NH > 1) ? $clog2(NH) : 1;

  logic [NBINS-1:0] lvds_rx;
  logic             pmt_in;
  logic             passthrough;
  logic             vetopmtlast;
  logic             usefullwidth;
  logic [OW-1:0]    phaseoffset;
  logic [7:0]       firingticks;
  logic [7:0]       deadticks;
  logic             resethist;
  logic [SW-1:0]    hist_sel;
  logic [HISTW-1:0] hist_data;
  logic [NCH-1:0]   trig_out;

  modport master (
    output lvds_rx, pmt_in, passthrough, vetopmtlast, usefullwidth,
           phaseoffset, firingticks, deadticks, resethist, hist_sel,
    input  hist_data, trig_out
  );

  modport slave (
    input  lvds_rx, pmt_in, passthrough, vetopmtlast, usefullwidth,
           phaseoffset, firingticks, deadticks, resethist, hist_sel,
    output hist_data, trig_out
  );
endinterface

// File: rtl/lvds_photon_trigger.sv
// lvds_photon_trigger
// Photon-trigger stage behind the LVDS deserialiser. Each clock one word of
// NBINS time-ordered bins is registered, optionally reduced to leading
// edges (also across the word boundary), and a phase-selected window of
// NCH*BPC bins is mapped onto the channels. Each channel runs a pulse FSM
// with programmable firing width and dead time. Every mapped bin has a
// saturating hit histogram, readable through a registered mux.
// Ports:
//   clkin  sole clock
//   rst    synchronous active-high reset
//   bus    lvds_photon_trigger_if.slave (samples, config, readout, triggers)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a channel hit
// FIRE  | trig_out high, counting down the firing width
// DEAD  | trig_out low, hits ignored until the dead time expires
module lvds_photon_trigger #(
  parameter int NBINS = 8,
  parameter int NCH   = 2,
  parameter int BPC   = 2,
  parameter int HISTW = 32
) (
  input  logic                   clkin,
  input  logic                   rst,
  lvds_photon_trigger_if.slave   bus
);

  localparam int NH = NCH * BPC;
  localparam int OW = (NBINS > 1) ? $clog2(NBINS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Sample registers
  logic [NBINS-1:0] w_q, w_d;
  logic [NBINS-1:0] wl_q, wl_d;

  // Hit decode
  logic [NBINS-1:0] phot;
  logic [NH-1:0]    map_bits;
  logic [NCH-1:0]   hit;
  logic [7:0]       fire_len;

  // Channel FSMs
  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [7:0]       cnt_q   [NCH];
  logic [7:0]       cnt_d   [NCH];
  logic [NCH-1:0]   trig_q, trig_d;

  // Histograms
  logic [1:0]       rh_q, rh_d;
  logic [HISTW-1:0] hcnt_q [NH];
  logic [HISTW-1:0] hcnt_d [NH];
  logic [HISTW-1:0] hist_data_q, hist_data_d;

  assign bus.trig_out  = trig_q;
  assign bus.hist_data = hist_data_q;

  // ---------------------------------------------------------------------
  // Sample capture; keeps running in passthrough so leading-edge history
  // is valid the moment passthrough is released.
  // ---------------------------------------------------------------------
  always_comb begin
    w_d  = bus.lvds_rx;
    wl_d = w_q;
  end

  // Leading-edge reduction: each bin is vetoed by the bin just before it
  // in time, which for bin 0 is the last bin of the previous word.
  always_comb begin
    phot = w_q;
    if (bus.vetopmtlast) begin
      phot = w_q & ~{w_q[NBINS-2:0], wl_q[NBINS-1]};
    end
  end

  // Histogram index h = c*BPC + k reads bin (phaseoffset + h) mod NBINS,
  // so the window wraps around the word instead of running off its end.
  always_comb begin
    map_bits = '0;
    for (int h = 0; h < NH; h++) begin
      map_bits[h] = phot[OW'((int'(bus.phaseoffset) + h) % NBINS)];
    end
  end

  always_comb begin
    hit = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c] = map_bits[c*BPC];
      for (int k = 1; k < BPC; k++) begin
        hit[c] = hit[c] | (bus.usefullwidth & map_bits[c*BPC + k]);
      end
    end
  end

  assign fire_len = (bus.firingticks == 8'd0) ? 8'd1 : bus.firingticks;

  // ---------------------------------------------------------------------
  // Channel FSMs. Counters are loaded on entry and leave the state on the
  // cycle they hold 1, so a load of N gives exactly N cycles in the state.
  // The terminal DEAD cycle doubles as the first idle sampling slot: a hit
  // there retriggers directly, so back-to-back pulses repeat every F+D
  // cycles with D low cycles between them.
  // ---------------------------------------------------------------------
  always_comb begin
    trig_d = '0;
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];

      case (state_q[c])
        ST_IDLE: begin
          if (hit[c]) begin
            state_d[c] = ST_FIRE;
            cnt_d[c]   = fire_len;
          end
        end
        ST_FIRE: begin
          if (cnt_q[c] == 8'd1) begin
            if (bus.deadticks != 8'd0) begin
              state_d[c] = ST_DEAD;
              cnt_d[c]   = bus.deadticks;
            end else begin
              state_d[c] = ST_IDLE;
              cnt_d[c]   = 8'd0;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - 8'd1;
          end
        end
        ST_DEAD: begin
          if (cnt_q[c] == 8'd1) begin
            if (hit[c]) begin
              state_d[c] = ST_FIRE;
              cnt_d[c]   = fire_len;
            end else begin
              state_d[c] = ST_IDLE;
              cnt_d[c]   = 8'd0;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - 8'd1;
          end
        end
        default: begin
          state_d[c] = ST_IDLE;
          cnt_d[c]   = 8'd0;
        end
      endcase

      if (bus.passthrough) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = 8'd0;
      end

      // Registered from the next state so the pulse starts on the same
      // edge the FSM leaves IDLE.
      trig_d[c] = (state_d[c] == ST_FIRE);
    end

    if (bus.passthrough) begin
      trig_d    = '0;
      trig_d[0] = bus.pmt_in;
    end
  end

  // ---------------------------------------------------------------------
  // Histograms: clear (two stages behind resethist) beats increment;
  // counters freeze during passthrough and saturate at all-ones.
  // ---------------------------------------------------------------------
  always_comb begin
    rh_d = {rh_q[0], bus.resethist};
    for (int h = 0; h < NH; h++) begin
      hcnt_d[h] = hcnt_q[h];
      if (rh_q[1]) begin
        hcnt_d[h] = '0;
      end else if (!bus.passthrough && map_bits[h] && (hcnt_q[h] != {HISTW{1'b1}})) begin
        hcnt_d[h] = hcnt_q[h] + HISTW'(1);
      end
    end
  end

  always_comb begin
    hist_data_d = '0;
    if (int'(bus.hist_sel) < NH) begin
      hist_data_d = hcnt_q[bus.hist_sel];
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clkin) begin
    if (rst) begin
      w_q         <= '0;
      wl_q        <= '0;
      trig_q      <= '0;
      rh_q        <= '0;
      hist_data_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= 8'd0;
      end
      for (int h = 0; h < NH; h++) begin
        hcnt_q[h] <= '0;
      end
    end else begin
      w_q         <= w_d;
      wl_q        <= wl_d;
      trig_q      <= trig_d;
      rh_q        <= rh_d;
      hist_data_q <= hist_data_d;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      for (int h = 0; h < NH; h++) begin
        hcnt_q[h] <= hcnt_d[h];
      end
    end
  end

endmodule
